// File: rtl/bin2bcd_converter_pkg.sv
// Shared constants and FSM encoding for the binary-to-BCD converter.
// Imported by the converter top and its per-digit correction cell.
package bin2bcd_converter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int DIGIT_W        = 4;
    localparam int DISP_DIGITS    = 4;
    localparam int SCRATCH_DIGITS = DISP_DIGITS + 1;
    localparam int SCRATCH_W      = SCRATCH_DIGITS * DIGIT_W;
    localparam int DISP_W         = DISP_DIGITS * DIGIT_W;
    localparam int BCD_MAX        = 9999;
    localparam int CONV_BITS      = 14;
    localparam int CNT_W          = 4;

    localparam logic [DISP_W-1:0] BCD_MAX_PACKED = 16'h9999;

endpackage

// File: rtl/bin2bcd_converter_bcd_add3.sv
// Double-dabble digit correction: any BCD digit >= 5 gets +3 before the shift,
// so the following shift carries cleanly into the next decimal digit.
module bcd_add3
    import bin2bcd_converter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digitIn,
    output logic [DIGIT_W-1:0] digitOut
);

    always_comb begin
        digitOut = digitIn;
        if (digitIn >= 4'd5) begin
            digitOut = digitIn + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_converter.sv
// Sequential 14-bit binary to 4-digit packed BCD converter, one bit per clock.
// Fixed 16-cycle start-to-start latency; result registered for a scan driver.
//
//   state | meaning
//   IDLE  | waiting for Start, outputs hold last result
//   CONV  | shift-add-3, one input bit per clock, 14 clocks
//   DONE  | publish NumberSig/Ovf, pulse Done, back to IDLE
module bin2bcd_converter
    import bin2bcd_converter_pkg::*;
#(
    parameter bit SAT_EN = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    input  logic [CONV_BITS-1:0] BinIn,
    output logic                 Busy,
    output logic                 Done,
    output logic [DISP_W-1:0]    NumberSig,
    output logic                 Ovf
);

    stateT                  state;
    logic [SCRATCH_W-1:0]   scratch;
    logic [SCRATCH_W-1:0]   corrected;
    logic [CONV_BITS-1:0]   shiftReg;
    logic [CNT_W-1:0]       bitCnt;
    logic                   tooBig;

    for (genvar i = 0; i < SCRATCH_DIGITS; i++) begin : gDigit
        bcd_add3 uAdd3 (
            .digitIn  (scratch[i*DIGIT_W +: DIGIT_W]),
            .digitOut (corrected[i*DIGIT_W +: DIGIT_W])
        );
    end

    // Inputs never exceed 16383, so the ten-thousands digit is 0 or 1 and the
    // corrected top bit is always zero; dropping it on the shift loses nothing.
    assign tooBig = (scratch[SCRATCH_W-1 -: DIGIT_W] != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            scratch   <= '0;
            shiftReg  <= '0;
            bitCnt    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            NumberSig <= '0;
            Ovf       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        shiftReg <= BinIn;
                        scratch  <= '0;
                        bitCnt   <= '0;
                        Busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    scratch  <= {corrected[SCRATCH_W-2:0], shiftReg[CONV_BITS-1]};
                    shiftReg <= {shiftReg[CONV_BITS-2:0], 1'b0};
                    bitCnt   <= bitCnt + 1'b1;
                    if (bitCnt == CNT_W'(CONV_BITS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    Ovf       <= tooBig;
                    NumberSig <= (tooBig && SAT_EN) ? BCD_MAX_PACKED : scratch[DISP_W-1:0];
                    Done      <= 1'b1;
                    Busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Randomized self-checking bench for bin2bcd_converter, saturating and wrapping
// builds side by side, against a decimal-arithmetic reference model.
module tb_bin2bcd_converter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Start = 1'b0;
    logic [13:0] BinIn = '0;

    logic        busySat, doneSat, ovfSat;
    logic [15:0] numSat;
    logic        busyWrap, doneWrap, ovfWrap;
    logic [15:0] numWrap;

    int checks = 0;
    int errors = 0;
    int prevSat = 0;
    int prevWrap = 0;

    always #5 CLK = ~CLK;

    bin2bcd_converter #(.SAT_EN(1'b1)) dutSat (
        .CLK(CLK), .RST(RST), .Start(Start), .BinIn(BinIn),
        .Busy(busySat), .Done(doneSat), .NumberSig(numSat), .Ovf(ovfSat)
    );

    bin2bcd_converter #(.SAT_EN(1'b0)) dutWrap (
        .CLK(CLK), .RST(RST), .Start(Start), .BinIn(BinIn),
        .Busy(busyWrap), .Done(doneWrap), .NumberSig(numWrap), .Ovf(ovfWrap)
    );

    task automatic checkVal(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by plain division, packed as hex nibbles.
    function automatic int toBcd(input int n);
        return ((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 + ((n / 10) % 10) * 16 + (n % 10);
    endfunction

    function automatic int modelSat(input int v);
        return (v > 9999) ? toBcd(9999) : toBcd(v);
    endfunction

    function automatic int modelWrap(input int v);
        return toBcd(v % 10000);
    endfunction

    task automatic checkHold();
        checkVal("holdSat", int'(numSat), prevSat);
        checkVal("holdWrap", int'(numWrap), prevWrap);
        checkVal("doneIdle", int'(doneSat), 0);
    endtask

    // Leaves the bench at #1 after the Done edge, i.e. inside the Done cycle.
    task automatic runConvert(input int v, input bit noise, input bit glitch77);
        int  n;
        bit  seen;
        Start = 1'b1;
        BinIn = 14'(v);
        @(posedge CLK); #1;
        checkVal("busyAtStart", int'(busySat), 1);
        checkVal("doneAtStart", int'(doneSat), 0);
        Start = 1'b0;
        BinIn = 14'($urandom);
        n = 0;
        seen = 1'b0;
        while (n < 40 && !seen) begin
            if (glitch77 && n == 4) begin
                Start = 1'b1;
                BinIn = 14'd77;
            end else if (noise) begin
                Start = 1'($urandom);
                BinIn = 14'($urandom);
            end else begin
                Start = 1'b0;
            end
            @(posedge CLK); #1;
            n++;
            if (doneSat) begin
                seen = 1'b1;
            end else begin
                checkVal("busyDuring", int'(busySat), 1);
                checkVal("midSat", int'(numSat), prevSat);
                checkVal("midWrap", int'(numWrap), prevWrap);
            end
        end
        Start = 1'b0;
        checkVal("latency", n, 15);
        checkVal("doneWrap", int'(doneWrap), 1);
        checkVal("busyInDone", int'(busySat), 0);
        checkVal("numSat", int'(numSat), modelSat(v));
        checkVal("numWrap", int'(numWrap), modelWrap(v));
        checkVal("ovfSat", int'(ovfSat), (v > 9999) ? 1 : 0);
        checkVal("ovfWrap", int'(ovfWrap), (v > 9999) ? 1 : 0);
        prevSat = modelSat(v);
        prevWrap = modelWrap(v);
    endtask

    task automatic idleGap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK); #1;
            checkHold();
        end
    endtask

    int edgeVals[] = '{0, 1, 9, 10, 99, 100, 999, 1000, 4999, 5000, 9998, 9999,
                       10000, 10001, 12345, 16383, 1234, 5678};

    initial begin
        int doneCount;

        repeat (3) @(posedge CLK);
        #1;
        checkVal("rstBusy", int'(busySat), 0);
        checkVal("rstDone", int'(doneSat), 0);
        checkVal("rstNum", int'(numSat), 0);
        checkVal("rstOvf", int'(ovfSat), 0);
        RST = 1'b0;
        idleGap(2);

        runConvert(1234, 1'b0, 1'b0);
        idleGap(3);

        // Back-to-back: second Start lands in the Done cycle.
        runConvert(0, 1'b0, 1'b0);
        runConvert(9999, 1'b0, 1'b0);
        idleGap(2);

        runConvert(12345, 1'b0, 1'b0);
        idleGap(1);

        runConvert(42, 1'b0, 1'b1);
        idleGap(20);

        // Reset abandons a conversion in progress.
        Start = 1'b1;
        BinIn = 14'd5678;
        @(posedge CLK); #1;
        Start = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        checkVal("abortBusy", int'(busySat), 0);
        checkVal("abortNum", int'(numSat), 0);
        checkVal("abortOvf", int'(ovfSat), 0);
        checkVal("abortDone", int'(doneSat), 0);
        // Reset wins over a simultaneous Start.
        Start = 1'b1;
        @(posedge CLK); #1;
        checkVal("rstOverStart", int'(busySat), 0);
        Start = 1'b0;
        RST = 1'b0;
        prevSat = 0;
        prevWrap = 0;
        doneCount = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (doneSat || doneWrap) doneCount++;
        end
        checkVal("abortNoDone", doneCount, 0);
        runConvert(5678, 1'b0, 1'b0);
        idleGap(1);

        foreach (edgeVals[i]) begin
            runConvert(edgeVals[i], 1'b1, 1'b0);
            if (i % 2 == 0) idleGap(1);
        end

        for (int i = 0; i < 1500; i++) begin
            runConvert(int'($urandom_range(0, 16383)), 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) idleGap(int'($urandom_range(1, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
